// File: rtl/ysyx_23060124_exu_seq.sv
// EXU sequencer: IDU accept -> operand latch -> ALU eval -> optional LSU handshake -> hold result to WBU.
// ALU op t->t+2, mem op waits on gnt/rvalid; WB holds o_valid until i_wb_ready. Perf counters under YSYX_23060124_EXU_PERF_EN.
module ysyx_23060124_exu_seq #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_valid,
    output logic o_ready,
    input  logic i_is_load,
    input  logic i_is_store,
    output logic o_opr_latch,
    output logic o_mem_req,
    input  logic i_mem_gnt,
    input  logic i_mem_rvalid,
    output logic o_valid,
    input  logic i_wb_ready,
    output logic o_mem_err
`ifdef YSYX_23060124_EXU_PERF_EN
    ,
    output logic [CNT_W-1:0] o_perf_inst,
    output logic [CNT_W-1:0] o_perf_stall
`endif
);
    localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MREQ, S_MWAIT, S_WB} state_t;

    state_t        state_q, state_d;
    logic          is_mem_q, is_mem_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          accept;
    logic          wb_hs;

    always_comb begin
        wb_hs       = (state_q == S_WB) && i_wb_ready;
        o_ready     = (state_q == S_IDLE) || wb_hs;
        accept      = i_valid && o_ready;
        o_opr_latch = accept;
        o_mem_req   = (state_q == S_MREQ);
        o_valid     = (state_q == S_WB);
        o_mem_err   = err_q;
    end

    always_comb begin
        state_d  = state_q;
        is_mem_d = is_mem_q;
        timer_d  = timer_q;
        err_d    = err_q;
        if (accept) begin
            is_mem_d = i_is_load | i_is_store;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = is_mem_q ? S_MREQ : S_WB;
            end
            S_MREQ: begin
                if (i_mem_gnt) begin
                    if (i_mem_rvalid) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_MWAIT;
                        timer_d = TW'(1);
                    end
                end
            end
            S_MWAIT: begin
                // Timer holds the index of the current MWAIT cycle, starting at 1.
                if (i_mem_rvalid) begin
                    state_d = S_WB;
                end else if ((MEM_TIMEOUT != 0) && (timer_q == TW'(MEM_TIMEOUT))) begin
                    err_d   = 1'b1;
                    state_d = S_WB;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WB: begin
                if (wb_hs) state_d = accept ? S_EXEC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            is_mem_q <= 1'b0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_mem_q <= is_mem_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

`ifdef YSYX_23060124_EXU_PERF_EN
    logic [CNT_W-1:0] inst_q, inst_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        inst_d  = inst_q;
        stall_d = stall_q;
        if (wb_hs) inst_d = inst_q + CNT_W'(1);
        if ((state_q == S_MREQ) || (state_q == S_MWAIT)) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            inst_q  <= '0;
            stall_q <= '0;
        end else begin
            inst_q  <= inst_d;
            stall_q <= stall_d;
        end
    end

    assign o_perf_inst  = inst_q;
    assign o_perf_stall = stall_q;
`endif
endmodule

// File: tb/tb_ysyx_23060124_exu_seq.sv
// Randomized bench for the EXU sequencer: timing-level model feeds a scoreboard checked at each WB handshake.
`timescale 1ns/1ps
module tb_ysyx_23060124_exu_seq;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic i_rst, i_valid, i_is_load, i_is_store, i_mem_gnt, i_mem_rvalid, i_wb_ready;
    logic o_ready, o_opr_latch, o_mem_req, o_valid, o_mem_err;
`ifdef YSYX_23060124_EXU_PERF_EN
    logic [31:0] o_perf_inst, o_perf_stall;
`endif

    ysyx_23060124_exu_seq #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_is_load    (i_is_load),
        .i_is_store   (i_is_store),
        .o_opr_latch  (o_opr_latch),
        .o_mem_req    (o_mem_req),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .o_valid      (o_valid),
        .i_wb_ready   (i_wb_ready),
        .o_mem_err    (o_mem_err)
`ifdef YSYX_23060124_EXU_PERF_EN
        ,
        .o_perf_inst  (o_perf_inst),
        .o_perf_stall (o_perf_stall)
`endif
    );

    typedef struct {
        int acc;
        int hs;
        int nreq;
        int nval;
        int err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int total = 0, bad = 0, cyc = 0;
    int err_model = 0, inst_model = 0, stall_model = 0;
    int lat_seen = 0, lat_cyc = 0, nreq = 0, nval = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Randomize every input whose value the DUT must ignore in the current state.
    task automatic junk();
        i_mem_gnt    = 1'($urandom_range(0, 1));
        i_mem_rvalid = 1'($urandom_range(0, 1));
        i_is_load    = 1'($urandom_range(0, 1));
        i_is_store   = 1'($urandom_range(0, 1));
    endtask

    // Monitor: attribute latches/req/valid cycles to the current instruction, compare on WB handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (i_rst) begin
                lat_seen = 0; nreq = 0; nval = 0;
            end else begin
                if (o_mem_req) nreq++;
                if (o_valid) nval++;
                if (o_valid && i_wb_ready) begin
                    chk("sb_nonempty", int'(sbq.size() != 0), 1);
                    if (sbq.size() != 0) begin
                        mon_e = sbq.pop_front();
                        chk("accept_cycle", (lat_seen != 0) ? lat_cyc : -1, mon_e.acc);
                        chk("wb_cycle", cyc, mon_e.hs);
                        chk("mem_req_cycles", nreq, mon_e.nreq);
                        chk("valid_cycles", nval, mon_e.nval);
                        chk("mem_err", int'(o_mem_err), mon_e.err);
                    end
                    lat_seen = 0; nreq = 0; nval = 0;
                end
                if (o_opr_latch) begin
                    chk("single_latch", lat_seen, 0);
                    lat_seen = 1;
                    lat_cyc  = cyc;
                end
            end
        end
    end

    // kind: 0/1 ALU, 2 load, 3 store, 4 load+store. g: cycles before grant. r: 0 = rvalid with gnt,
    // 1..5 = rvalid in that MWAIT cycle, >TO = never (timeout). w: WB stall cycles.
    task automatic run_batch(input int n, input bit directed);
        bit b2b;
        bit mem;
        int kind, g, r, w, gap, t_acc, mw, nreq_e, v;
        b2b = 1'b0;
        for (int k = 0; k < n; k++) begin
            kind = $urandom_range(0, 4);
            g    = $urandom_range(0, 3);
            r    = ($urandom_range(0, 7) == 0) ? TO + 4 : $urandom_range(0, 5);
            w    = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2);
            if (directed) begin
                case (k)
                    0: begin kind = 0; w = 0; end
                    1: begin kind = 2; g = 2; r = 2; w = 0; end
                    2: begin kind = 1; w = 5; end
                    3: begin kind = 3; g = 0; r = TO + 4; w = 0; end
                    4: begin kind = 0; w = 0; end
                    5: begin kind = 1; w = 0; end
                    default: ;
                endcase
            end
            if (!b2b) begin
                for (int i = 0; i < gap; i++) begin
                    junk();
                    i_valid    = 1'b0;
                    i_wb_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                i_wb_ready = 1'($urandom_range(0, 1));
            end
            junk();
            i_valid    = 1'b1;
            i_is_load  = (kind == 2) || (kind == 4);
            i_is_store = (kind == 3) || (kind == 4);
            t_acc  = cyc;
            mem    = (kind >= 2);
            nreq_e = mem ? g + 1 : 0;
            mw     = (mem && r != 0) ? ((r > TO) ? TO : r) : 0;
            v      = t_acc + 2 + nreq_e + mw;
            if (mem && r > TO) err_model = 1;
            sbq.push_back('{t_acc, v + w, nreq_e, w + 1, err_model});
            inst_model++;
            stall_model += nreq_e + mw;
            tick();
            junk();
            i_valid    = 1'($urandom_range(0, 1));
            i_wb_ready = 1'($urandom_range(0, 1));
            tick();
            if (mem) begin
                for (int i = 0; i <= g; i++) begin
                    junk();
                    i_valid   = 1'($urandom_range(0, 1));
                    i_mem_gnt = (i == g);
                    if (i == g) i_mem_rvalid = (r == 0);
                    tick();
                end
                for (int i = 1; i <= mw; i++) begin
                    junk();
                    i_valid      = 1'($urandom_range(0, 1));
                    i_mem_rvalid = (i == r);
                    tick();
                end
            end
            for (int i = 0; i < w; i++) begin
                junk();
                i_valid    = 1'($urandom_range(0, 1));
                i_wb_ready = 1'b0;
                tick();
            end
            junk();
            i_valid    = 1'b0;
            i_wb_ready = 1'b1;
            b2b = (k < n - 1) && ((directed && k == 4) || ($urandom_range(0, 1) == 1));
            if (!b2b) tick();
        end
        i_valid = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        i_is_load = 1'b0; i_is_store = 1'b0; i_wb_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_wb_ready = 1'b0;
        #2;
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_latch", int'(o_opr_latch), 0);
        chk("rst_mem_req", int'(o_mem_req), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_err", int'(o_mem_err), 0);
        tick();
        tick();
        i_rst = 1'b0;

        run_batch(40, 1'b1);
        tick();
`ifdef YSYX_23060124_EXU_PERF_EN
        chk("perf_inst", int'(o_perf_inst), inst_model);
        chk("perf_stall", int'(o_perf_stall), stall_model);
`endif

        // Load that gets granted, then reset lands while waiting for rvalid.
        i_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0;
        tick();
        i_valid = 1'b0; i_is_load = 1'b0;
        tick();
        chk("pre_rst_req", int'(o_mem_req), 1);
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        tick();
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_mem_req", int'(o_mem_req), 0);
        chk("arst_valid", int'(o_valid), 0);
        chk("arst_ready", int'(o_ready), 1);
        chk("arst_err_clr", int'(o_mem_err), 0);
`ifdef YSYX_23060124_EXU_PERF_EN
        chk("arst_perf_inst", int'(o_perf_inst), 0);
        chk("arst_perf_stall", int'(o_perf_stall), 0);
`endif
        tick();
        i_rst = 1'b0;
        i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stale_valid", int'(o_valid), 0);
            chk("stale_req", int'(o_mem_req), 0);
            chk("stale_ready", int'(o_ready), 1);
        end
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_wb_ready = 1'b0;
        err_model = 0; inst_model = 0; stall_model = 0;

        run_batch(15, 1'b0);
        tick();
        chk("sb_drained", sbq.size(), 0);
`ifdef YSYX_23060124_EXU_PERF_EN
        chk("perf_inst2", int'(o_perf_inst), inst_model);
        chk("perf_stall2", int'(o_perf_stall), stall_model);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
